// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory load/store unit.
//   size_e    : access size encoding carried on req_size
//   LANES     : byte lanes per 32-bit memory word
//   lane_mask : byte-enable mask for a store of a given size at a given lane
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_e;

  localparam int unsigned LANES = 4;

  function automatic logic [LANES-1:0] lane_mask(input size_e size, input logic [1:0] lane);
    case (size)
      SZ_BYTE: lane_mask = 4'b0001 << lane;
      SZ_HALF: lane_mask = 4'b0011 << lane;
      SZ_WORD: lane_mask = 4'b1111;
      default: lane_mask = 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/load_extend.sv
// Combinational lane extract and sign/zero extension of a loaded word.
//   word_i     : registered 32-bit RAM word
//   lane_i     : byte offset within the word
//   size_i     : access size
//   unsigned_i : 1 = zero-extend, 0 = sign-extend
//   data_o     : extended load result (0 for illegal size)
module load_extend
  import dmem_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  lane_i,
  input  size_e       size_i,
  input  logic        unsigned_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = word_i[8*lane_i +: 8];
  assign half_sel = lane_i[1] ? word_i[31:16] : word_i[15:0];

  always_comb begin
    data_o = '0;
    case (size_i)
      SZ_BYTE: data_o = {{24{~unsigned_i & byte_sel[7]}}, byte_sel};
      SZ_HALF: data_o = {{16{~unsigned_i & half_sel[15]}}, half_sel};
      SZ_WORD: data_o = word_i;
      default: data_o = '0;
    endcase
  end

endmodule

// File: rtl/dmem_lsu.sv
// Data memory with a load/store front end, one-deep response slot.
//   clk, rst_n               : clock, async active-low reset
//   req_valid/req_ready      : request handshake
//   req_we, req_size,
//   req_unsigned, req_addr,
//   req_wdata                : request fields (store/load, size, extension, address, data)
//   rsp_valid/rsp_ready      : response handshake
//   rsp_rdata, rsp_err       : extended load data (0 for stores/errors), error flag
module dmem_lsu
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  logic [31:0] mem [DEPTH];

  logic [IDX_W-1:0] idx;
  logic [1:0]       lane;
  size_e            size;
  logic             out_of_range, misaligned, err, accept, wr_en;
  logic [LANES-1:0] wmask;
  logic [31:0]      wdata_rep;

  logic        rsp_valid_q, rsp_valid_d;
  logic        err_q, err_d;
  logic [31:0] word_q, word_d;
  logic [1:0]  lane_q, lane_d;
  size_e       size_q, size_d;
  logic        uns_q, uns_d;
  logic [31:0] ext_data;

  assign idx          = req_addr[IDX_W+1:2];
  assign lane         = req_addr[1:0];
  assign size         = size_e'(req_size);
  assign out_of_range = |(req_addr >> (IDX_W + 2));
  assign misaligned   = ((size == SZ_HALF) && lane[0]) || ((size == SZ_WORD) && (lane != 2'b00));
  assign err          = out_of_range || misaligned || (size == SZ_ILL);

  assign req_ready = !rsp_valid_q || rsp_ready;
  assign accept    = req_valid && req_ready;
  // rst_n gate keeps a request presented during reset from landing in RAM.
  assign wr_en     = accept && req_we && !err && rst_n;
  assign wmask     = lane_mask(size, lane);

  // Replicate store data across lanes so the byte mask alone picks the target.
  always_comb begin
    wdata_rep = req_wdata;
    case (size)
      SZ_BYTE: wdata_rep = {4{req_wdata[7:0]}};
      SZ_HALF: wdata_rep = {2{req_wdata[15:0]}};
      default: wdata_rep = req_wdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int unsigned b = 0; b < LANES; b++) begin
        if (wmask[b]) mem[idx][8*b +: 8] <= wdata_rep[8*b +: 8];
      end
    end
  end

  // Stores and errors capture a zero word, so the extend stage yields 0 for them.
  always_comb begin
    rsp_valid_d = rsp_valid_q;
    err_d       = err_q;
    word_d      = word_q;
    lane_d      = lane_q;
    size_d      = size_q;
    uns_d       = uns_q;
    if (accept) begin
      rsp_valid_d = 1'b1;
      err_d       = err;
      word_d      = (!req_we && !err) ? mem[idx] : '0;
      lane_d      = lane;
      size_d      = size;
      uns_d       = req_unsigned;
    end else if (rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      err_q       <= 1'b0;
      word_q      <= '0;
      lane_q      <= '0;
      size_q      <= SZ_BYTE;
      uns_q       <= 1'b0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      err_q       <= err_d;
      word_q      <= word_d;
      lane_q      <= lane_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
    end
  end

  load_extend u_load_extend (
    .word_i     (word_q),
    .lane_i     (lane_q),
    .size_i     (size_q),
    .unsigned_i (uns_q),
    .data_o     (ext_data)
  );

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_valid_q ? ext_data : '0;
  assign rsp_err   = rsp_valid_q && err_q;

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed self-checking bench for dmem_lsu (DEPTH=64).
module tb_dmem_lsu;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int vectors;
  int miscompares;

  dmem_lsu #(.DEPTH(64), .ADDR_W(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd);
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = sz;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wd;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One accepted transaction with rsp_ready=1; leaves the response visible.
  task automatic xfer(input logic we, input logic [1:0] sz, input logic uns,
                      input logic [31:0] addr, input logic [31:0] wd);
    @(negedge clk);
    drive(we, sz, uns, addr, wd);
    tick();
    req_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b1;
    req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
    #2;
    vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b want 0", rsp_valid); end
    vectors++; if (rsp_rdata !== 32'h0) begin miscompares++; $display("FAIL reset_rdata got %h want 00000000", rsp_rdata); end
    vectors++; if (rsp_err !== 1'b0) begin miscompares++; $display("FAIL reset_err got %b want 0", rsp_err); end
    vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready got %b want 1", req_ready); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_word;
    xfer(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
    vectors++; if (rsp_valid !== 1'b1) begin miscompares++; $display("FAIL st_word_valid got %b want 1", rsp_valid); end
    vectors++; if (rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin miscompares++; $display("FAIL st_word_rsp got %h/%b want 00000000/0", rsp_rdata, rsp_err); end
    xfer(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    vectors++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0) begin miscompares++; $display("FAIL ld_word_flags got %b/%b want 1/0", rsp_valid, rsp_err); end
    vectors++; if (rsp_rdata !== 32'hDEADBEEF) begin miscompares++; $display("FAIL ld_word got %h want deadbeef", rsp_rdata); end
  endtask

  task automatic test_byte_half;
    xfer(1'b1, 2'b00, 1'b0, 32'h12, 32'h1234567A);
    vectors++; if (rsp_err !== 1'b0 || rsp_rdata !== 32'h0) begin miscompares++; $display("FAIL st_byte_rsp got %h/%b want 00000000/0", rsp_rdata, rsp_err); end
    xfer(1'b0, 2'b00, 1'b0, 32'h13, 32'h0);
    vectors++; if (rsp_rdata !== 32'hFFFFFFDE) begin miscompares++; $display("FAIL ld_sbyte_13 got %h want ffffffde", rsp_rdata); end
    xfer(1'b0, 2'b00, 1'b1, 32'h12, 32'h0);
    vectors++; if (rsp_rdata !== 32'h0000007A) begin miscompares++; $display("FAIL ld_ubyte_12 got %h want 0000007a", rsp_rdata); end
    xfer(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    vectors++; if (rsp_rdata !== 32'hDE7ABEEF) begin miscompares++; $display("FAIL ld_word_merged got %h want de7abeef", rsp_rdata); end
    xfer(1'b0, 2'b01, 1'b0, 32'h12, 32'h0);
    vectors++; if (rsp_rdata !== 32'hFFFFDE7A) begin miscompares++; $display("FAIL ld_shalf_12 got %h want ffffde7a", rsp_rdata); end
    xfer(1'b0, 2'b01, 1'b1, 32'h10, 32'h0);
    vectors++; if (rsp_rdata !== 32'h0000BEEF) begin miscompares++; $display("FAIL ld_uhalf_10 got %h want 0000beef", rsp_rdata); end
    xfer(1'b0, 2'b00, 1'b0, 32'h10, 32'h0);
    vectors++; if (rsp_rdata !== 32'hFFFFFFEF) begin miscompares++; $display("FAIL ld_sbyte_10 got %h want ffffffef", rsp_rdata); end
  endtask

  task automatic test_errors;
    xfer(1'b1, 2'b10, 1'b0, 32'h11, 32'h01020304);
    vectors++; if (rsp_err !== 1'b1 || rsp_rdata !== 32'h0) begin miscompares++; $display("FAIL st_mis_word got %h/%b want 00000000/1", rsp_rdata, rsp_err); end
    xfer(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    vectors++; if (rsp_rdata !== 32'hDE7ABEEF || rsp_err !== 1'b0) begin miscompares++; $display("FAIL ld_after_mis got %h/%b want de7abeef/0", rsp_rdata, rsp_err); end
    xfer(1'b0, 2'b01, 1'b0, 32'h13, 32'h0);
    vectors++; if (rsp_err !== 1'b1 || rsp_rdata !== 32'h0) begin miscompares++; $display("FAIL ld_mis_half got %h/%b want 00000000/1", rsp_rdata, rsp_err); end
    xfer(1'b0, 2'b11, 1'b0, 32'h10, 32'h0);
    vectors++; if (rsp_err !== 1'b1 || rsp_rdata !== 32'h0) begin miscompares++; $display("FAIL ld_ill_size got %h/%b want 00000000/1", rsp_rdata, rsp_err); end
    xfer(1'b1, 2'b10, 1'b0, 32'h0, 32'h11223344);
    xfer(1'b1, 2'b10, 1'b0, 32'hFC, 32'hCAFEF00D);
    xfer(1'b0, 2'b10, 1'b0, 32'hFC, 32'h0);
    vectors++; if (rsp_rdata !== 32'hCAFEF00D || rsp_err !== 1'b0) begin miscompares++; $display("FAIL ld_last_word got %h/%b want cafef00d/0", rsp_rdata, rsp_err); end
    xfer(1'b0, 2'b10, 1'b0, 32'h100, 32'h0);
    vectors++; if (rsp_err !== 1'b1 || rsp_rdata !== 32'h0) begin miscompares++; $display("FAIL ld_oor got %h/%b want 00000000/1", rsp_rdata, rsp_err); end
    xfer(1'b1, 2'b10, 1'b0, 32'h100, 32'hFFFFFFFF);
    vectors++; if (rsp_err !== 1'b1) begin miscompares++; $display("FAIL st_oor got %b want 1", rsp_err); end
    xfer(1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
    vectors++; if (rsp_rdata !== 32'h11223344) begin miscompares++; $display("FAIL word0_unchanged got %h want 11223344", rsp_rdata); end
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    drive(1'b1, 2'b10, 1'b0, 32'h20, 32'h55AA1234);
    tick();
    vectors++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0) begin miscompares++; $display("FAIL b2b_store got %b/%h want 1/00000000", rsp_valid, rsp_rdata); end
    drive(1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
    tick();
    vectors++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h55AA1234) begin miscompares++; $display("FAIL b2b_load got %b/%h want 1/55aa1234", rsp_valid, rsp_rdata); end
    req_valid = 1'b0;
    tick();
    vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL b2b_drain got %b want 0", rsp_valid); end
  endtask

  task automatic test_backpressure;
    @(negedge clk);
    rsp_ready = 1'b0;
    drive(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    tick();
    drive(1'b0, 2'b10, 1'b0, 32'hFC, 32'h0);
    vectors++; if (req_ready !== 1'b0) begin miscompares++; $display("FAIL bp_ready_low got %b want 0", req_ready); end
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDE7ABEEF || req_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL bp_hold[%0d] got v=%b d=%h r=%b want v=1 d=de7abeef r=0", i, rsp_valid, rsp_rdata, req_ready);
      end
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    #1;
    vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL bp_release_ready got %b want 1", req_ready); end
    tick();
    req_valid = 1'b0;
    vectors++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hCAFEF00D) begin miscompares++; $display("FAIL bp_second got %b/%h want 1/cafef00d", rsp_valid, rsp_rdata); end
    tick();
    vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL bp_drain got %b want 0", rsp_valid); end
  endtask

  task automatic test_reset_mid_stall;
    @(negedge clk);
    rsp_ready = 1'b0;
    drive(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    tick();
    drive(1'b1, 2'b10, 1'b0, 32'h10, 32'h00000000);
    tick();
    vectors++; if (rsp_valid !== 1'b1) begin miscompares++; $display("FAIL stall_valid got %b want 1", rsp_valid); end
    #2;
    rst_n = 1'b0;
    req_valid = 1'b0;
    #1;
    vectors++; if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin miscompares++; $display("FAIL async_reset got %b/%h/%b want 0/00000000/0", rsp_valid, rsp_rdata, rsp_err); end
    @(negedge clk);
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    xfer(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    vectors++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDE7ABEEF) begin miscompares++; $display("FAIL post_reset_ld got %b/%h want 1/de7abeef", rsp_valid, rsp_rdata); end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_word();
    test_byte_half();
    test_errors();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_stall();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dmem_lsu.md
Name: dmem_lsu

Overview:
- Parametrised data memory with a load/store front end.
- Supports byte, halfword and word accesses, with signed or unsigned load extension.
- Detects misaligned and out-of-range accesses.
- Synchronous read with a valid/ready handshake on both request and response, so it can sit behind a pipelined memory stage that may stall.
- Connects to the control unit's memory-op decode and feeds the writeback mux.

Parameters:
- DEPTH, 64: number of 32-bit words; power of two, at least 4.
- ADDR_W, 32: width of the byte address.
- IDX_W, $clog2(DEPTH): word-index width (derived; do not override).

Ports:
- clk, input, 1: rising-edge clock.
- rst_n, input, 1: asynchronous, active-low reset.
- req_valid, input, 1: request present.
- req_ready, output, 1: request accepted this cycle when req_valid && req_ready.
- req_we, input, 1: 1 = store, 0 = load.
- req_size, input, 2: 00 byte, 01 half, 10 word, 11 illegal.
- req_unsigned, input, 1: loads only; 1 = zero-extend, 0 = sign-extend.
- req_addr, input, ADDR_W: byte address.
- req_wdata, input, 32: store data, taken from the low-order bits.
- rsp_valid, output, 1: response present.
- rsp_ready, input, 1: consumer takes the response.
- rsp_rdata, output, 32: extended load data; 0 for stores and errors.
- rsp_err, output, 1: misaligned, out-of-range or illegal size.

Behaviour:
- Reset (async, rst_n low):
  - rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - The response register and pending lane/size/sign state are cleared.
  - RAM contents are not reset.
  - A request in flight when reset asserts is dropped; no partial write occurs after reset.
- Handshake:
  - req_ready = !rsp_valid || rsp_ready. This gives a single response slot and full throughput when rsp_ready=1.
  - A request is accepted on a clock edge where req_valid && req_ready.
  - Latency is 1: rsp_valid is high in the cycle after acceptance.
  - rsp_valid, rsp_rdata and rsp_err hold stable while rsp_valid && !rsp_ready.
  - When a response is taken and no new request is accepted in the same cycle, rsp_valid falls next edge.
- Address decode:
  - word index = req_addr[IDX_W+1:2]; lane = req_addr[1:0].
  - Out of range: any req_addr bit at or above IDX_W+2 is set.
  - Misaligned: half with lane[0]=1, or word with lane!=00.
  - Any error or size==11 gives rsp_err=1 and rsp_rdata=0, and no RAM write occurs.
- Store, on accept, with no error:
  - byte: write wdata[7:0] into lane byte, mask 0001<<lane.
  - half: write wdata[15:0] into lanes {lane+1, lane}, mask 0011<<lane.
  - word: write all four lanes.
  - Unmasked bytes are unchanged; there is no read-modify-write bubble.
- Load:
  - The RAM word is read synchronously at the accept edge; lane/size/unsigned are registered alongside it.
  - The extract/extend stage runs combinationally on the registered word.
  - byte: select RAM byte [8*lane+7 : 8*lane], then extend bit 7.
  - half: select bits [16*lane[1]+15 : 16*lane[1]], then extend bit 15.
  - word: pass through unchanged.
- Little-endian lane ordering throughout.
- Read-during-write to the same word on the same edge cannot occur on a single port. Back-to-back accesses: a store at cycle N followed by a load of the same word at N+1 returns the stored data (write-then-read ordering).
- Stores produce a response with rsp_rdata=0 so the issuer can retire in order.

Decomposition:
- Shared package dmem_pkg:
  - size encodings SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10, SZ_ILL=2'b11.
  - constant LANES=4.
  - function lane_mask(size, lane).
- One sub-module: load_extend. Takes the 32-bit word, lane, size and unsigned flag; outputs the 32-bit result. Purely combinational; instantiated after the read register.

Test Plan:
- Store word 0xDEADBEEF at 0x10, then load word at 0x10 -> rsp_rdata=0xDEADBEEF one cycle after accept, rsp_err=0.
- After the above, store byte 0x7A at 0x12, then load signed byte at 0x13 -> 0xFFFFFFDE. Load unsigned byte at 0x12 -> 0x0000007A. Load word at 0x10 -> 0xDE7ABEEF.
- Load signed half at 0x12 -> 0xFFFFDE7A. Load unsigned half at 0x10 -> 0x0000BEEF.
- Misalignment and illegal size:
  - Store word at 0x11 -> rsp_err=1, and a later word load at 0x10 still returns 0xDE7ABEEF.
  - Load half at 0x13 -> rsp_err=1, rsp_rdata=0.
  - size=11 -> rsp_err=1.
- Out of range: with DEPTH=64, load at 0x100 -> rsp_err=1; store at 0x100 -> rsp_err=1 and word 0 is unchanged.
- Backpressure and reset:
  - Hold rsp_ready=0 for 3 cycles with req_valid=1 -> req_ready=0, response held stable, second request not accepted until rsp_ready=1.
  - Assert rst_n=0 mid-stall -> rsp_valid=0 immediately (asynchronous), and RAM word 0x10 is still readable after release.
